// File: rtl/mlp_pkg.sv
// Shared constants, FSM state type and output clamp helper for the dense MLP layer.
// Q8.8 activations/weights, 784 inputs by 200 neurons, with the accumulator sized
// so a full 784-term dot product of worst-case products cannot overflow.
package mlp_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC   = 8;
  localparam int N_IN   = 784;
  localparam int N_OUT  = 200;
  localparam int ACC_W  = 42;
  localparam int RELU   = 1;

  // Working width for the clamp helper; any accumulator up to this width fits.
  localparam int SAT_W  = 64;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    LAST,
    OUT,
    FIN
  } state_t;

  // Optional ReLU followed by saturation to a signed dw-bit range.
  // The result is returned at SAT_W bits; callers keep the low dw bits.
  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] v,
    input logic                    relu_en,
    input int                      dw
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    r  = v;
    if (relu_en && (v < SAT_W'(0))) begin
      r = SAT_W'(0);
    end
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with synchronous clear, plus the combinational
// rescale (arithmetic shift by FRAC), optional ReLU and saturation of the sum.
// The accumulator is the only state; result follows it combinationally so the
// caller can register it in the same cycle the sum becomes final.
module mac_unit
  import mlp_pkg::*;
#(
  parameter int DATA_W = mlp_pkg::DATA_W,
  parameter int FRAC   = mlp_pkg::FRAC,
  parameter int ACC_W  = mlp_pkg::ACC_W,
  parameter int RELU   = mlp_pkg::RELU
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic        [DATA_W-1:0] result
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    shifted;

  // Full-precision product; both operands are signed so the multiply is signed.
  assign prod = x * w;

  // Accumulate one sign-extended product per enabled cycle; clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  // Back to Q8.8 by arithmetic shift (rounds toward minus infinity).
  assign shifted = acc >>> FRAC;

  // ReLU happens before the clamp, so a negative sum never saturates low.
  assign result = DATA_W'(sat_relu(SAT_W'(shifted), RELU != 0, DATA_W));

endmodule

// File: rtl/dense_mac_layer.sv
// One fully connected layer: holds an N_IN activation vector, streams N_IN*N_OUT
// weights from the shift RAM in neuron-major order and emits one saturated Q8.8
// result per neuron. Each neuron takes N_IN issue cycles, one cycle to drain the
// RAM read latency (LAST) and one cycle to emit (OUT), giving N_IN+2 per neuron.
// The weight RAM has no address input, so exactly N_IN*N_OUT reads per pass keep
// it aligned; a mid-pass reset relies on the RAM being reset on the same rst.
module dense_mac_layer
  import mlp_pkg::*;
#(
  parameter int DATA_W = mlp_pkg::DATA_W,
  parameter int FRAC   = mlp_pkg::FRAC,
  parameter int N_IN   = mlp_pkg::N_IN,
  parameter int N_OUT  = mlp_pkg::N_OUT,
  parameter int ACC_W  = mlp_pkg::ACC_W,
  parameter int RELU   = mlp_pkg::RELU
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_we,
  input  logic [9:0]        in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              start,
  output logic              wgt_rd_en,
  input  logic [DATA_W-1:0] wgt_rdata,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_idx,
  output logic              done
);

  localparam int          K_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);
  localparam logic [7:0]  N_LAST = 8'(N_OUT - 1);
  localparam logic [10:0] N_IN_L = 11'(N_IN);

  state_t            state;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    k_d;
  logic              issue_d;
  logic [7:0]        n;
  logic [DATA_W-1:0] x_buf [N_IN];
  logic              addr_ok;
  logic              mac_clear;
  logic [DATA_W-1:0] mac_result;

  // Indices at or beyond N_IN are dropped rather than aliased onto low entries.
  assign addr_ok = ({1'b0, in_addr} < N_IN_L);

  // Activation buffer: loaded only between passes, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) begin
        x_buf[i] <= '0;
      end
    end else if (in_we && !busy && addr_ok) begin
      x_buf[in_addr[K_W-1:0]] <= in_wdata;
    end
  end

  // Delay the issue index and strobe by one cycle to line up with RAM rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_d     <= '0;
      issue_d <= 1'b0;
    end else begin
      k_d     <= k;
      issue_d <= wgt_rd_en;
    end
  end

  // Start every pass and every neuron with an empty accumulator.
  assign mac_clear = (state == OUT) || ((state == IDLE) && start);

  mac_unit #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W),
    .RELU   (RELU)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .acc_en (issue_d),
    .x      (x_buf[k_d]),
    .w      (wgt_rdata),
    .result (mac_result)
  );

  // Pass sequencer with registered read strobe, status and result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      n         <= '0;
      wgt_rd_en <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            wgt_rd_en <= 1'b1;
            k         <= '0;
            n         <= '0;
          end
        end
        RUN: begin
          if (k == K_LAST) begin
            state     <= LAST;
            wgt_rd_en <= 1'b0;
            k         <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        LAST: begin
          state <= OUT;
        end
        OUT: begin
          out_valid <= 1'b1;
          out_idx   <= n;
          out_data  <= mac_result;
          k         <= '0;
          if (n == N_LAST) begin
            state <= FIN;
          end else begin
            n         <= n + 1'b1;
            state     <= RUN;
            wgt_rd_en <= 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          wgt_rd_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
